// File: rtl/stream_chk.sv
// AXI-Stream byte checker: compares accepted beats against a pushed expected-byte FIFO, with a ready pattern.
// Optional in-frame idle timeout enabled by defining STREAM_CHK_TIMEOUT_EN.
module stream_chk #(
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [7:0]    exp_data,
  input  logic          exp_last,
  input  logic          exp_push,
  output logic          exp_full,
  output logic [AW:0]   exp_count,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  input  logic [7:0]    ready_pattern,
  output logic [15:0]   byte_count,
  output logic [15:0]   frame_count,
  output logic [15:0]   err_count,
  output logic          mismatch,
  output logic          underflow,
  output logic          overflow,
  output logic          timeout,
  output logic          err_pulse,
  output logic          frame_done
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t        state, state_nxt;
  logic          in_frame;
  logic [2:0]    ptr;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [8:0]    head;
  logic          empty, accept, push, pop;
  logic          overflow_ev, check_fail, underflow_ev, timeout_ev, err_ev;

  assign exp_full      = (count == (AW+1)'(DEPTH));
  assign exp_count     = count;
  assign empty         = (count == '0);
  assign head          = mem[rd_ptr];
  assign s_axis_tready = ready_pattern[ptr];
  assign accept        = s_axis_tvalid & s_axis_tready;

  // clear wins over everything: a beat is still accepted but neither checked nor counted.
  assign push         = exp_push & ~exp_full & ~clear;
  assign pop          = accept & ~empty & ~clear;
  assign overflow_ev  = exp_push & exp_full & ~clear;
  assign check_fail   = pop & ((s_axis_tdata != head[7:0]) | (s_axis_tlast != head[8]));
  assign underflow_ev = accept & empty & ~clear;
  assign err_ev       = check_fail | underflow_ev | timeout_ev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr <= '0;
    else if (clear) ptr <= '0;
    else            ptr <= ptr + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {exp_last, exp_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear || timeout_ev)  state_nxt = IDLE;
    else if (accept)          state_nxt = s_axis_tlast ? IDLE : IN_FRAME;
  end

  always_comb begin
    in_frame = (state == IN_FRAME);
  end

`ifdef STREAM_CHK_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout_ev = in_frame & ~accept & ~clear & (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (clear) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (!in_frame || accept || timeout_ev) idle_cnt <= '0;
      else                                   idle_cnt <= idle_cnt + 16'd1;
      if (timeout_ev) timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0) & in_frame;
  assign timeout_ev     = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count  <= '0;
      frame_count <= '0;
      err_count   <= '0;
      mismatch    <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      err_pulse   <= 1'b0;
      frame_done  <= 1'b0;
    end else if (clear) begin
      byte_count  <= '0;
      frame_count <= '0;
      err_count   <= '0;
      mismatch    <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
      err_pulse   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (accept)                          byte_count  <= byte_count + 16'd1;
      if (accept && s_axis_tlast)          frame_count <= frame_count + 16'd1;
      if (err_ev && err_count != 16'hFFFF) err_count   <= err_count + 16'd1;
      if (check_fail)   mismatch  <= 1'b1;
      if (underflow_ev) underflow <= 1'b1;
      if (overflow_ev)  overflow  <= 1'b1;
      err_pulse  <= err_ev;
      frame_done <= accept & s_axis_tlast;
    end
  end

endmodule

// File: doc/stream_chk.md
# stream_chk

AXI-Stream byte checker that sits directly downstream of the `m_axis_data_*` receive port of an `i2c_master` or `i2c_slave` instance in the I2C bench. It consumes received bytes and applies a programmable back-pressure pattern on `tready`. Each accepted beat is compared against an expected-byte FIFO loaded by the test sequence, in the same push style as `stream_gen`. Byte, frame and error counts are reported, with sticky error flags.

## Interface
- `DEPTH`, 8: expected FIFO depth in entries; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: FIFO pointer width; derived, do not override.
- `TIMEOUT`, 1024: idle-cycle limit inside a frame (used only with `STREAM_CHK_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of FIFO, counters, flags, state and pattern pointer.
- `exp_data` in 8: expected byte.
- `exp_last` in 1: expected tlast for that byte.
- `exp_push` in 1: write {`exp_last`, `exp_data`} into the FIFO.
- `exp_full` out 1: FIFO holds `DEPTH` entries.
- `exp_count` out AW+1: FIFO occupancy.
- `s_axis_tdata` in 8: received byte (from `m_axis_data_tdata_*`).
- `s_axis_tvalid` in 1: received byte valid.
- `s_axis_tlast` in 1: received byte is last of frame.
- `s_axis_tready` out 1: checker accepts a beat this cycle.
- `ready_pattern` in 8: back-pressure mask; `8'hFF` means always ready.
- `byte_count` out 16: accepted beats.
- `frame_count` out 16: accepted beats that carried tlast.
- `err_count` out 16: failed checks.
- `mismatch` out 1: sticky; a data or last compare failed.
- `underflow` out 1: sticky; a beat was accepted while the FIFO was empty.
- `overflow` out 1: sticky; `exp_push` arrived while `exp_full`.
- `timeout` out 1: sticky timeout flag (tied 0 without the macro).
- `err_pulse` out 1: one-cycle pulse per failed check.
- `frame_done` out 1: one-cycle pulse on the accepted tlast beat.

## Operation
- Accept = `s_axis_tvalid & s_axis_tready`.
- `s_axis_tready = ready_pattern[ptr]`. `ptr` is a 3-bit register that increments every cycle and wraps from 7 to 0, independent of tvalid.
- FIFO push: occurs when `exp_push & ~exp_full`.
  - Push while full is dropped and sets `overflow`, even if a pop happens in the same cycle.
- FIFO pop: occurs on accept when the FIFO is non-empty.
  - Simultaneous push and pop leaves `exp_count` unchanged.
- Check on accept with a non-empty FIFO:
  - Fails if `s_axis_tdata != head.data` or `s_axis_tlast != head.last`.
  - A fail sets `mismatch`, pulses `err_pulse` and increments `err_count`.
- Accept with an empty FIFO: no pop; sets `underflow`, pulses `err_pulse`, increments `err_count`.
- Counter widths and limits:
  - `byte_count` and `frame_count` wrap modulo 2^16.
  - `err_count` saturates at 16'hFFFF.
- State machine:
  - IDLE → IN_FRAME on an accept with tlast=0.
  - IN_FRAME → IDLE on an accept with tlast=1.
  - An accept with tlast=1 in IDLE is a one-beat frame and stays in IDLE.
  - `frame_done` pulses on every accepted tlast beat.
- `clear` has priority over a same-cycle accept or push: the beat is still accepted but not checked or counted, and the push is dropped.
- Reset or `clear` mid-frame: state returns to IDLE; no error is raised.

## Timing
- Check latency: all counters and flags update on the clock edge that accepts the beat.
  - `err_pulse` and `frame_done` are high for exactly the following cycle.
- FIFO head is read combinationally; a byte pushed in cycle N can be checked in cycle N+1.
- Reset values:
  - `exp_count`=0, `exp_full`=0.
  - All counters = 0.
  - `mismatch`, `underflow`, `overflow`, `timeout`, `err_pulse`, `frame_done` = 0.
  - State = IDLE, `ptr`=0, so `s_axis_tready`=`ready_pattern[0]`.
- `exp_full`, `exp_count` and `s_axis_tready` are combinational from registers plus `ready_pattern`; no input→output path through tvalid.

## Configuration
- `STREAM_CHK_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in IN_FRAME and resets on every accept.
  - When the counter reaches `TIMEOUT`: set `timeout`, increment `err_count`, pulse `err_pulse`, return to IDLE.
- `STREAM_CHK_TIMEOUT_EN` undefined: no idle counter, `timeout` tied 0, `TIMEOUT` unused.

## Test plan
- Push 0x22,0x2A,0x37(last); pattern 8'hFF; drive the same 3 beats → `byte_count`=3, `frame_count`=1, `err_count`=0, one `frame_done`, `exp_count`=0.
- Push 0x55(last); receive 0x54 with tlast=1 → `mismatch`=1, `err_count`=1, one `err_pulse`; state IDLE.
- FIFO empty; one beat 0xA5 accepted → `underflow`=1, `err_count`=1, `exp_count` stays 0.
- DEPTH=8: push 9 bytes without pops → `exp_full`=1, `exp_count`=8, `overflow`=1.
- Pattern 8'b0101_0101, tvalid held high for 16 cycles → exactly 8 beats accepted, on even `ptr` values only.
- With `STREAM_CHK_TIMEOUT_EN`, TIMEOUT=16: accept 1 non-last beat, then idle 16 cycles → `timeout`=1, `err_count`=1, state IDLE; assert `clear` → all flags and counters 0.
